// File: rtl/moving_avg_mc_if.sv
// Sample/result bus of the multi-channel averager: the producer drives samples,
// the averager drives in_ready and the result strobe.
interface moving_avg_mc_if #(
    parameter int N    = 12,
    parameter int CH_W = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic [N-1:0]    in_data;
    logic            out_valid;
    logic [CH_W-1:0] out_ch;
    logic [N-1:0]    out_data;
    logic            out_full;

    modport master (
        output in_valid, in_ch, in_data,
        input  in_ready, out_valid, out_ch, out_data, out_full
    );

    modport slave (
        input  in_valid, in_ch, in_data,
        output in_ready, out_valid, out_ch, out_data, out_full
    );
endinterface

// File: rtl/moving_avg_mc.sv
// Time-multiplexed moving/block averager: per-channel history in one RAM at {ch, slot},
// two-stage pipeline (accept+RAM read, then accumulate+emit), hardware clear sequencer.
module moving_avg_mc #(
    parameter int N          = 12,
    parameter int LOG2_DEPTH = 8,
    parameter int CHANNELS   = 4,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           mode,
    moving_avg_mc_if.slave bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = N + LOG2_DEPTH;
    localparam int AW    = CH_W + LOG2_DEPTH;
    localparam int NCH   = 1 << CH_W;
    localparam int CNT_W = LOG2_DEPTH + 1;

    localparam logic [AW-1:0]         CLR_LAST  = AW'(CHANNELS * DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(DEPTH);
    localparam logic [LOG2_DEPTH-1:0] SLOT_LAST = LOG2_DEPTH'(DEPTH - 1);
    localparam logic [CH_W:0]         CH_LIM    = (CH_W + 1)'(CHANNELS);

    typedef enum logic {CLEAR, RUN} state_t;

    function automatic logic [N-1:0] avg_floor(input logic [ACC_W-1:0] a);
        return a[ACC_W-1:LOG2_DEPTH];
    endfunction

    function automatic logic [CNT_W-1:0] fill_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    state_t          state;
    logic            ready;
    logic [AW-1:0]   clr_cnt;
    logic            mode_q;

    logic [ACC_W-1:0]      acc  [NCH];
    logic [LOG2_DEPTH-1:0] slot [NCH];
    logic [CNT_W-1:0]      fill [NCH];
    logic [N-1:0]          hist [2**AW];

    logic                  accept;
    logic [LOG2_DEPTH-1:0] rd_slot;
    logic [AW-1:0]         rd_addr;

    logic            vld_p0;
    logic [CH_W-1:0] ch_p0;
    logic [N-1:0]    data_p0;
    logic            mode_p0;
    logic [N-1:0]    old_p0;

    logic            vld_p1;
    logic [CH_W-1:0] ch_p1;
    logic [N-1:0]    avg_p1;
    logic            full_p1;

    logic [ACC_W-1:0]      acc_cur;
    logic [LOG2_DEPTH-1:0] slot_cur;
    logic [CNT_W-1:0]      cnt_nx;
    logic [ACC_W-1:0]      sum_in;
    logic [ACC_W-1:0]      acc_slide;
    logic [ACC_W-1:0]      acc_nx;
    logic [N-1:0]          avg;
    logic                  emit;

    // Stage 0: accept, forward the slot of a same-channel sample still in stage 1, issue RAM read.
    assign accept  = bus.in_valid && ready && ({1'b0, bus.in_ch} < CH_LIM);
    assign rd_slot = (vld_p0 && (ch_p0 == bus.in_ch)) ? slot[bus.in_ch] + LOG2_DEPTH'(1)
                                                       : slot[bus.in_ch];
    assign rd_addr = {bus.in_ch, rd_slot};

    always_ff @(posedge clk) begin
        if (accept) begin
            ch_p0   <= bus.in_ch;
            data_p0 <= bus.in_data;
            mode_p0 <= mode;
        end
    end

    // The clear sequencer owns the write port while clearing; a sample finishing then is not stored.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            hist[clr_cnt] <= '0;
        end else if (vld_p0 && !mode_p0) begin
            hist[{ch_p0, slot_cur}] <= data_p0;
        end
        old_p0 <= hist[rd_addr];
    end

    // Stage 1: accumulate against the old history word and decide whether to emit.
    assign acc_cur   = acc[ch_p0];
    assign slot_cur  = slot[ch_p0];
    assign cnt_nx    = fill_inc(fill[ch_p0]);
    assign sum_in    = acc_cur + ACC_W'(data_p0);
    assign acc_slide = sum_in - ACC_W'(old_p0);

    always_comb begin
        emit   = 1'b0;
        avg    = '0;
        acc_nx = acc_cur;
        if (mode_p0) begin
            emit   = vld_p0 && (slot_cur == SLOT_LAST);
            avg    = avg_floor(sum_in);
            acc_nx = (slot_cur == SLOT_LAST) ? '0 : sum_in;
        end else begin
            emit   = vld_p0;
            avg    = avg_floor(acc_slide);
            acc_nx = acc_slide;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            ready   <= 1'b0;
            clr_cnt <= '0;
            mode_q  <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            ch_p1   <= '0;
            avg_p1  <= '0;
            full_p1 <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                acc[c]  <= '0;
                slot[c] <= '0;
                fill[c] <= '0;
            end
        end else begin
            mode_q <= mode;
            vld_p0 <= accept;
            vld_p1 <= emit;
            if (emit) begin
                ch_p1   <= ch_p0;
                avg_p1  <= avg;
                full_p1 <= (cnt_nx == CNT_MAX);
            end
            case (state)
                CLEAR: begin
                    for (int c = 0; c < NCH; c++) begin
                        acc[c]  <= '0;
                        slot[c] <= '0;
                        fill[c] <= '0;
                    end
                    if (flush) begin
                        clr_cnt <= '0;
                    end else if (clr_cnt == CLR_LAST) begin
                        clr_cnt <= '0;
                        state   <= RUN;
                        ready   <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                RUN: begin
                    if (vld_p0) begin
                        acc[ch_p0]  <= acc_nx;
                        slot[ch_p0] <= slot_cur + LOG2_DEPTH'(1);
                        fill[ch_p0] <= cnt_nx;
                    end
                    if (flush || (mode != mode_q)) begin
                        clr_cnt <= '0;
                        state   <= CLEAR;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_ch    = ch_p1;
    assign bus.out_data  = avg_p1;
    assign bus.out_full  = full_p1;
endmodule

// File: tb/tb_moving_avg_mc.sv
// Scoreboard bench for moving_avg_mc (N=12, DEPTH=4, 2 channels): a behavioural model
// queues expected results with their due cycle; a monitor pops and compares on each strobe.
module tb_moving_avg_mc;
    localparam int N          = 12;
    localparam int LOG2_DEPTH = 2;
    localparam int CHANNELS   = 2;
    localparam int CH_W       = 1;
    localparam int DEPTH      = 4;

    typedef struct {
        int ch;
        int data;
        int full;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic mode = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    exp_t sb[$];
    int   m_hist[CHANNELS][DEPTH];
    int   m_acc[CHANNELS];
    int   m_slot[CHANNELS];
    int   m_fill[CHANNELS];
    int   m_mode = 0;

    moving_avg_mc_if #(.N(N), .CH_W(CH_W)) bus ();

    moving_avg_mc #(.N(N), .LOG2_DEPTH(LOG2_DEPTH), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .mode  (mode),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic model_clear();
        for (int c = 0; c < CHANNELS; c++) begin
            m_acc[c]  = 0;
            m_slot[c] = 0;
            m_fill[c] = 0;
            for (int s = 0; s < DEPTH; s++) m_hist[c][s] = 0;
        end
    endtask

    task automatic model_push(input int ch, input int d);
        exp_t e;
        int   sum;
        m_fill[ch] = (m_fill[ch] < DEPTH) ? m_fill[ch] + 1 : DEPTH;
        e.ch   = ch;
        e.full = (m_fill[ch] == DEPTH) ? 1 : 0;
        e.cyc  = cyc + 2;
        if (m_mode == 0) begin
            m_acc[ch] = m_acc[ch] - m_hist[ch][m_slot[ch]] + d;
            m_hist[ch][m_slot[ch]] = d;
            e.data = m_acc[ch] / DEPTH;
            sb.push_back(e);
        end else begin
            sum = m_acc[ch] + d;
            if (m_slot[ch] == DEPTH - 1) begin
                e.data = sum / DEPTH;
                sb.push_back(e);
                m_acc[ch] = 0;
            end else begin
                m_acc[ch] = sum;
            end
        end
        m_slot[ch] = (m_slot[ch] + 1) % DEPTH;
    endtask

    // Drive one sample once in_ready is seen; caller is positioned just after a rising edge.
    task automatic send(input int ch, input int d);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_ch    = CH_W'(ch);
        bus.in_data  = N'(d);
        model_push(ch, d);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_len(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check(tag, n, 8);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        clear_len("flush_clear_len");
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_cycle", cyc, e.cyc);
                check("out_ch", int'(bus.out_ch), e.ch);
                check("out_data", int'(bus.out_data), e.data);
                check("out_full", int'(bus.out_full), e.full);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;
        model_clear();

        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_ch", int'(bus.out_ch), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_full", int'(bus.out_full), 0);
        clear_len("reset_clear_len");

        // sliding warm-up on one channel
        for (int i = 0; i < 5; i++) send(0, 100);
        idle(3);
        pulse_flush();

        // interleaved channels
        for (int i = 0; i < 4; i++) begin
            send(0, 4000);
            send(1, 8);
        end
        idle(3);
        pulse_flush();

        // back-to-back same-channel ramp
        for (int i = 1; i <= 5; i++) send(1, i);
        idle(3);
        pulse_flush();

        // full-scale, then flush with a sample in flight
        for (int i = 0; i < 4; i++) send(0, 4095);
        bus.in_valid = 1'b1;
        bus.in_ch    = '0;
        bus.in_data  = N'(4095);
        flush        = 1'b1;
        model_push(0, 4095);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        model_clear();
        clear_len("inflight_flush_clear_len");
        send(0, 8);
        idle(3);

        // random sliding traffic with gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
        end
        idle(3);

        // mode toggle alone clears, then block mode
        mode = 1'b1;
        @(posedge clk); #1;
        m_mode = 1;
        model_clear();
        clear_len("mode_clear_len");
        send(0, 10); send(0, 20); send(0, 30); send(0, 41);
        send(0, 4);  send(0, 4);  send(0, 4);  send(0, 4);
        idle(3);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
        end
        idle(4);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
